// File: rtl/stage_mdu_pkg.sv
// stage_mdu_pkg: op encodings, FSM states and op-class helpers for the MDU.
// Optional build macro: MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU encodings.
package stage_mdu_pkg;

  localparam int MD_OP_LEN = 4;

  typedef logic [MD_OP_LEN-1:0] md_op_t;

  localparam md_op_t MD_OP_NONE  = 4'd0;
  localparam md_op_t MD_OP_MULT  = 4'd1;
  localparam md_op_t MD_OP_MULTU = 4'd2;
  localparam md_op_t MD_OP_DIV   = 4'd3;
  localparam md_op_t MD_OP_DIVU  = 4'd4;
  localparam md_op_t MD_OP_MTHI  = 4'd5;
  localparam md_op_t MD_OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam md_op_t MD_OP_MADD  = 4'd7;
  localparam md_op_t MD_OP_MADDU = 4'd8;
  localparam md_op_t MD_OP_MSUB  = 4'd9;
  localparam md_op_t MD_OP_MSUBU = 4'd10;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_md_class(input md_op_t op);
    logic r;
    r = 1'b0;
    case (op)
      MD_OP_MULT, MD_OP_MULTU,
      MD_OP_DIV,  MD_OP_DIVU:  r = 1'b1;
`ifdef MDU_MADD_EN
      MD_OP_MADD, MD_OP_MADDU,
      MD_OP_MSUB, MD_OP_MSUBU: r = 1'b1;
`endif
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

  // Multiply-class ops use the multiply latency, the rest the divide one.
  function automatic logic is_mul_lat(input md_op_t op);
    logic r;
    r = 1'b0;
    case (op)
      MD_OP_MULT, MD_OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      MD_OP_MADD, MD_OP_MADDU,
      MD_OP_MSUB, MD_OP_MSUBU: r = 1'b1;
`endif
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stage_mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath producing {hi,lo} results.
// Optional build macro: MDU_MADD_EN adds multiply-accumulate/subtract ops.
module mdu_arith
  import stage_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t           md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_by_zero
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    acc;
  logic [W2-1:0]    ext_a_s;
  logic [W2-1:0]    ext_b_s;
  logic [W2-1:0]    ext_a_u;
  logic [W2-1:0]    ext_b_u;
  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    prod_u;
  logic [W2-1:0]    res;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] safe_b;
  logic [WIDTH-1:0] q_m;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;

  // Products, magnitude-based signed divide, unsigned divide, result select.
  always_comb begin
    acc     = {hi, lo};
    ext_a_s = {{WIDTH{a[WIDTH-1]}}, a};
    ext_b_s = {{WIDTH{b[WIDTH-1]}}, b};
    ext_a_u = {{WIDTH{1'b0}}, a};
    ext_b_u = {{WIDTH{1'b0}}, b};
    prod_s  = ext_a_s * ext_b_s;
    prod_u  = ext_a_u * ext_b_u;

    b_zero  = (b == '0);
    sign_a  = a[WIDTH-1];
    sign_b  = b[WIDTH-1];
    mag_a   = sign_a ? (~a + 1'b1) : a;
    mag_b   = sign_b ? (~b + 1'b1) : b;
    q_m     = b_zero ? '0 : (mag_a / mag_b);
    r_m     = b_zero ? '0 : (mag_a % mag_b);
    q_s     = (sign_a ^ sign_b) ? (~q_m + 1'b1) : q_m;
    r_s     = sign_a ? (~r_m + 1'b1) : r_m;
    safe_b  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    q_u     = b_zero ? '0 : (a / safe_b);
    r_u     = b_zero ? '0 : (a % safe_b);

    res         = acc;
    div_by_zero = 1'b0;
    case (md_op)
      MD_OP_MULT:  res = prod_s;
      MD_OP_MULTU: res = prod_u;
      MD_OP_DIV: begin
        res         = {r_s, q_s};
        div_by_zero = b_zero;
      end
      MD_OP_DIVU: begin
        res         = {r_u, q_u};
        div_by_zero = b_zero;
      end
`ifdef MDU_MADD_EN
      MD_OP_MADD:  res = acc + prod_s;
      MD_OP_MADDU: res = acc + prod_u;
      MD_OP_MSUB:  res = acc - prod_s;
      MD_OP_MSUBU: res = acc - prod_u;
`endif
      default:     res = acc;
    endcase
  end

  assign res_hi = res[W2-1:WIDTH];
  assign res_lo = res[WIDTH-1:0];

endmodule

// File: rtl/stage_mdu.sv
// stage_mdu: HI/LO registers and multi-cycle multiply/divide sequencing.
// Optional build macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module stage_mdu
  import stage_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           md_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] p_hi_q;
  logic [WIDTH-1:0] p_hi_d;
  logic [WIDTH-1:0] p_lo_q;
  logic [WIDTH-1:0] p_lo_d;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_by_zero;
  logic             md_class;

  mdu_arith #(
    .WIDTH(WIDTH)
  ) u_arith (
    .md_op      (md_op),
    .a          (rs_data),
    .b          (rt_data),
    .hi         (hi_q),
    .lo         (lo_q),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .div_by_zero(div_by_zero)
  );

  assign md_class  = is_md_class(md_op);
  assign busy      = (cnt_q != '0);
  assign stall_req = busy | (start & md_class);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Next-state: accept ops in IDLE, count down in RUN, commit on last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (md_class) begin
            // A zero divisor re-commits the current HI/LO, leaving them intact.
            p_hi_d  = div_by_zero ? hi_q : res_hi;
            p_lo_d  = div_by_zero ? lo_q : res_lo;
            cnt_d   = is_mul_lat(md_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_d = ST_RUN;
          end else if (md_op == MD_OP_MTHI) begin
            hi_d = rs_data;
          end else if (md_op == MD_OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
    end
  end

endmodule

// File: tb/tb_stage_mdu.sv
// tb_stage_mdu: vector table, corner sequences and random ops vs a model.
// Honours MDU_MADD_EN the same way as the design.
module tb_stage_mdu;
  import stage_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int nvec = 0;
  int nerr = 0;

  stage_mdu #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .busy     (busy),
    .stall_req(stall_req),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference behaviour straight from the arithmetic definitions.
  function automatic void model(input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l,
                                output logic [31:0] nh, output logic [31:0] nl,
                                output int lat);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned acc;
    logic [63:0]     r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    acc = {h, l};
    nh  = h;
    nl  = l;
    lat = 0;
    r   = '0;
    case (op)
      MD_OP_MULT:  begin r = 64'(sa * sb); {nh, nl} = r; lat = 5; end
      MD_OP_MULTU: begin r = ua * ub; {nh, nl} = r; lat = 5; end
      MD_OP_DIV: begin
        lat = 10;
        if (b != 0) begin nl = 32'(sa / sb); nh = 32'(sa % sb); end
      end
      MD_OP_DIVU: begin
        lat = 10;
        if (b != 0) begin nl = a / b; nh = a % b; end
      end
      MD_OP_MTHI: nh = a;
      MD_OP_MTLO: nl = a;
`ifdef MDU_MADD_EN
      MD_OP_MADD:  begin r = acc + 64'(sa * sb); {nh, nl} = r; lat = 5; end
      MD_OP_MADDU: begin r = acc + ua * ub; {nh, nl} = r; lat = 5; end
      MD_OP_MSUB:  begin r = acc - 64'(sa * sb); {nh, nl} = r; lat = 5; end
      MD_OP_MSUBU: begin r = acc - ua * ub; {nh, nl} = r; lat = 5; end
`endif
      default: ;
    endcase
  endfunction

  // Issue one op and count the busy cycles that follow.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic exp_stall,
                        output int bc);
    @(negedge clk);
    start   = 1'b1;
    md_op   = op;
    rs_data = a;
    rt_data = b;
    #1;
    chk($sformatf("stall_req op%0d", op), {31'b0, stall_req},
        {31'b0, exp_stall});
    @(negedge clk);
    start = 1'b0;
    md_op = MD_OP_NONE;
    bc    = 0;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      @(negedge clk);
    end
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    int bc;
    run_op(MD_OP_MTHI, h, 32'h0, 1'b0, bc);
    run_op(MD_OP_MTLO, l, 32'h0, 1'b0, bc);
  endtask

  initial begin
    vec_t        tbl[$];
    int          bc;
    logic [31:0] mh;
    logic [31:0] ml;
    logic [31:0] nh;
    logic [31:0] nl;
    int          lat;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    tbl.push_back('{MD_OP_MULT,  32'hFFFFFFFF, 32'h2, 32'h0, 32'h0,
                    32'hFFFFFFFF, 32'hFFFFFFFE, 5});
    tbl.push_back('{MD_OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0,
                    32'h00000001, 32'hFFFFFFFE, 5});
    tbl.push_back('{MD_OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0,
                    32'h3FFFFFFF, 32'h00000001, 5});
    tbl.push_back('{MD_OP_DIV,   32'hFFFFFFF9, 32'h2, 32'h0, 32'h0,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    tbl.push_back('{MD_OP_DIV,   32'h7, 32'hFFFFFFFE, 32'h0, 32'h0,
                    32'h00000001, 32'hFFFFFFFD, 10});
    tbl.push_back('{MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h1,
                    32'h00000000, 32'h80000000, 10});
    tbl.push_back('{MD_OP_DIVU,  32'd100, 32'd7, 32'h0, 32'h0,
                    32'd2, 32'd14, 10});
    tbl.push_back('{MD_OP_DIVU,  32'h1234, 32'h0, 32'h11, 32'h22,
                    32'h11, 32'h22, 10});
    tbl.push_back('{MD_OP_DIV,   32'h1234, 32'h0, 32'h33, 32'h44,
                    32'h33, 32'h44, 10});
    tbl.push_back('{MD_OP_NONE,  32'hDEAD, 32'hBEEF, 32'h5, 32'h6,
                    32'h5, 32'h6, 0});
    tbl.push_back('{4'd15,       32'hDEAD, 32'hBEEF, 32'h7, 32'h8,
                    32'h7, 32'h8, 0});
    tbl.push_back('{MD_OP_MTHI,  32'hABCD, 32'h0, 32'h1, 32'h2,
                    32'hABCD, 32'h2, 0});
`ifdef MDU_MADD_EN
    tbl.push_back('{4'd7, 32'd3, 32'd4, 32'h0, 32'd10,
                    32'h0, 32'd22, 5});
    tbl.push_back('{4'd9, 32'd3, 32'd4, 32'h0, 32'd10,
                    32'hFFFFFFFF, 32'hFFFFFFFE, 5});
`else
    tbl.push_back('{4'd7, 32'd3, 32'd4, 32'h0, 32'd10,
                    32'h0, 32'd10, 0});
    tbl.push_back('{4'd9, 32'd3, 32'd4, 32'h0, 32'd10,
                    32'h0, 32'd10, 0});
`endif

    // Reset state and combinational stall_req during reset.
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset stall idle", {31'b0, stall_req}, 32'h0);
    start = 1'b1;
    md_op = MD_OP_MULT;
    #1;
    chk("reset stall mult", {31'b0, stall_req}, 32'h1);
    md_op = MD_OP_MTHI;
    #1;
    chk("reset stall mthi", {31'b0, stall_req}, 32'h0);
    start = 1'b0;
    md_op = MD_OP_NONE;
    @(negedge clk);
    reset = 1'b0;

    // Table of directed vectors.
    foreach (tbl[i]) begin
      set_hilo(tbl[i].pre_hi, tbl[i].pre_lo);
      run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].exp_busy > 0, bc);
      chk($sformatf("vec%0d busy", i), 32'(bc), 32'(tbl[i].exp_busy));
      chk($sformatf("vec%0d hi", i), hi, tbl[i].exp_hi);
      chk($sformatf("vec%0d lo", i), lo, tbl[i].exp_lo);
    end

    // Start while busy is ignored.
    set_hilo(32'h77, 32'h66);
    @(negedge clk);
    start   = 1'b1;
    md_op   = MD_OP_MULT;
    rs_data = 32'd3;
    rt_data = 32'd4;
    @(negedge clk);
    chk("ign busy1", {31'b0, busy}, 32'h1);
    md_op   = MD_OP_MTLO;
    rs_data = 32'h5;
    #1;
    chk("ign stall", {31'b0, stall_req}, 32'h1);
    @(negedge clk);
    md_op   = MD_OP_MTHI;
    rs_data = 32'h9;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_OP_NONE;
    chk("ign hi mid", hi, 32'h77);
    chk("ign lo mid", lo, 32'h66);
    bc = 2;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    chk("ign busy cycles", 32'(bc), 32'd5);
    chk("ign hi", hi, 32'h0);
    chk("ign lo", lo, 32'd12);
    @(negedge clk);
    chk("ign lo later", lo, 32'd12);

    // Reset in the middle of a multiply.
    set_hilo(32'h55, 32'h44);
    @(negedge clk);
    start   = 1'b1;
    md_op   = MD_OP_MULT;
    rs_data = 32'd3;
    rt_data = 32'd4;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_OP_NONE;
    @(negedge clk);
    @(negedge clk);
    chk("rst pre busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst busy after", {31'b0, busy}, 32'h0);
    chk("rst hi after", hi, 32'h0);
    chk("rst lo after", lo, 32'h0);

    // Random ops against the model.
    mh = $urandom;
    ml = $urandom;
    set_hilo(mh, ml);
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'h0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      model(op, a, b, mh, ml, nh, nl, lat);
      run_op(op, a, b, lat > 0, bc);
      chk($sformatf("rnd%0d op%0d busy", i, op), 32'(bc), 32'(lat));
      chk($sformatf("rnd%0d op%0d hi", i, op), hi, nh);
      chk($sformatf("rnd%0d op%0d lo", i, op), lo, nl);
      mh = nh;
      ml = nl;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/stage_mdu.md
# stage_mdu

Multi-cycle multiply/divide unit serving the execute stage of the pipelined MIPS core. It holds the HI/LO registers and executes MULT/MULTU/DIV/DIVU with configurable latency. It also executes MTHI/MTLO and exposes HI/LO for MFHI/MFLO. Decode uses `busy` and `stall_req` to hold any HI/LO-touching instruction while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MULT_CYCLES`, 5: busy cycles for multiply-class ops; must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for divide-class ops; must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: `md_op` is valid this cycle.
- `md_op` in `MD_OP_LEN`: operation select, `MD_OP_*`.
- `rs_data` in `WIDTH`: operand A, or the MTHI/MTLO source.
- `rt_data` in `WIDTH`: operand B.
- `busy` out 1: an operation is in flight.
- `stall_req` out 1: `busy | (start & md_op is mult/div-class)`; combinational.
- `hi` out `WIDTH`: HI register.
- `lo` out `WIDTH`: LO register.

## Operation
- State: `hi`, `lo`, pending result `{p_hi, p_lo}`, down-counter `cnt` (width `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)`). `busy = (cnt != 0)`. This is a two-state FSM: IDLE (`cnt==0`) and RUN.
- IDLE, `start` with a mult/div-class op:
  - Compute result from `rs_data`/`rt_data`.
  - Latch it into `p_hi`/`p_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
- Arithmetic:
  - MULT: signed `WIDTH`×`WIDTH`→`2*WIDTH`; `{hi,lo} = product`.
  - MULTU: the same, unsigned.
  - DIV: signed; `lo` = quotient truncated toward zero, `hi` = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero: the busy period runs normally, but `hi`/`lo` are left unchanged at completion.
- RUN: `cnt` decrements every edge. On the edge where `cnt==1`, `hi<=p_hi` and `lo<=p_lo`, and `cnt` becomes 0.
- MTHI/MTLO with `start` in IDLE: write `hi`/`lo` from `rs_data` on the next edge; `busy` does not assert.
- `start` while `busy`: ignored entirely. Decode must stall; the bench checks that no state changes.
- `start` with `MD_OP_NONE` or an unknown encoding: no-op.
- `reset` at any time, including mid-operation: `hi=0`, `lo=0`, `p_hi=0`, `p_lo=0`, `cnt=0`. The in-flight result is discarded.

## Timing
- Reset values: `busy=0`, `stall_req` follows its inputs, `hi=0`, `lo=0`.
- A mult/div `start` sampled at edge k:
  - `busy` is high during cycles k+1 … k+N, where N is the op's latency.
  - New `hi`/`lo` are visible, and `busy` is low, from the cycle after edge k+N.
- `stall_req` is high in the start cycle itself, so a following MFHI/MFLO in decode is stalled with no bubble gap.
- MTHI/MTLO: new value visible in the cycle after the start edge; zero busy cycles.
- MFHI/MFLO read `hi`/`lo` directly. There is no bypass of pending results; correctness relies on the stall.
- Back-to-back: a new mult/div is accepted in the first cycle with `busy==0`.

## Configuration
- `MDU_MADD_EN` defined:
  - Adds MADD/MADDU/MSUB/MSUBU: `{hi,lo} ± product` (signed or unsigned), modulo `2*WIDTH`.
  - The accumulate base is the `{hi,lo}` value at start.
  - Latency is `MULT_CYCLES`.
  - These ops count as mult/div-class for `stall_req`.
- `MDU_MADD_EN` undefined: those encodings are no-ops; `busy` and `hi`/`lo` are untouched.

## Structure
- `def.v` holds `MD_OP_LEN` and `MD_OP_NONE`, `MD_OP_MULT`, `MD_OP_MULTU`, `MD_OP_DIV`, `MD_OP_DIVU`, `MD_OP_MTHI`, `MD_OP_MTLO`. `MD_OP_MADD`, `MD_OP_MADDU`, `MD_OP_MSUB`, `MD_OP_MSUBU` are guarded by `MDU_MADD_EN`.
- The decode stage gains an `md_op` output and stalls on `stall_req` for MFHI/MFLO/MTHI/MTLO/mult/div.
- One sub-module: `mdu_arith`. It is purely combinational; it maps `md_op`, operands, and the current `{hi,lo}` to `{res_hi, res_lo, div_by_zero}`. `stage_mdu` holds all registers and the counter.

## Test plan
- Reset, then MULT with `rs=0xFFFFFFFF` (−1), `rt=2`:
  - `busy` high exactly 5 cycles.
  - Then `hi=0xFFFFFFFF`, `lo=0xFFFFFFFE`.
- MULTU with `rs=0xFFFFFFFF`, `rt=2`: `hi=0x00000001`, `lo=0xFFFFFFFE`.
- DIV with `rs=-7`, `rt=2`:
  - `busy` high exactly 10 cycles.
  - Then `lo=0xFFFFFFFD` (−3), `hi=0xFFFFFFFF` (−1).
- DIVU by 0 after `hi=0x11`, `lo=0x22` were set via MTHI/MTLO:
  - `busy` high for 10 cycles.
  - `hi`/`lo` remain `0x11`/`0x22`.
- MULT accepted, then `start`+MTLO `0x5` asserted while `busy`:
  - The MTLO is ignored.
  - `lo` ends at the product, not `0x5`.
- MULT of 3×4 with `reset` pulsed at busy cycle 3:
  - `busy` falls immediately.
  - `hi=lo=0`, and `hi`/`lo` never take the product.
  - With `MDU_MADD_EN`, a separate case: MADD of 3×4 onto `{hi,lo}={0,10}` → `lo=22`.
